// File: rtl/trenes_sensores.sv
// Sensor conditioner for the two-track crossing: synchronizes and debounces the
// four raw entry/exit sensors and keeps a saturating occupancy count per track.
module trenes_sensores #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             E0,
    input  logic             X0,
    input  logic             E1,
    input  logic             X1,
    input  logic             clr_err,
    output logic             V0,
    output logic             V1,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [1:0]       err
);

    localparam int               RUN_W    = $clog2(DEB_CYCLES);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic             ovf;
        logic             unf;
    } occ_t;

    // Channel order: bit0 = E0, bit1 = X0, bit2 = E1, bit3 = X1.
    logic [3:0]       raw;
    logic [3:0]       s1, s2, stable, stable_d, ev;
    logic [RUN_W-1:0] run [4];

    assign raw = {X1, E1, X0, E0};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1       <= '0;
            s2       <= '0;
            stable   <= '0;
            stable_d <= '0;
            ev       <= '0;
            // NOTE: the run counters are a small register array, not a RAM, so they
            // reset with everything else; an aborted debounce must not survive reset.
            for (int i = 0; i < 4; i++) run[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments make s1->s2 and stable->stable_d true
            // pipeline stages; blocking ones would collapse them into one flop.
            s1       <= raw;
            s2       <= s1;
            stable_d <= stable;
            ev       <= stable & ~stable_d;
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == stable[i]) begin
                    run[i] <= '0;
                end else if (run[i] == RUN_LAST) begin
                    stable[i] <= s2[i];
                    run[i]    <= '0;
                end else begin
                    run[i] <= run[i] + 1'b1;
                end
            end
        end
    end

    function automatic occ_t occ_next(input logic [CNT_W-1:0] cnt, input logic ent,
                                      input logic ext);
        occ_t r;
        r.cnt = cnt;
        r.ovf = 1'b0;
        r.unf = 1'b0;
        if (ent && !ext) begin
            if (cnt == CNT_MAX) r.ovf = 1'b1;
            else                r.cnt = cnt + 1'b1;
        end else if (ext && !ent) begin
            if (cnt == '0) r.unf = 1'b1;
            else           r.cnt = cnt - 1'b1;
        end
        return r;
    endfunction

    occ_t nxt0, nxt1;

    // NOTE: every always_comb output is fully assigned on every path, so no latch.
    always_comb begin
        nxt0 = occ_next(cnt0, ev[0], ev[1]);
        nxt1 = occ_next(cnt1, ev[2], ev[3]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
            V0   <= 1'b0;
            V1   <= 1'b0;
            err  <= 2'b00;
        end else begin
            cnt0 <= nxt0.cnt;
            cnt1 <= nxt1.cnt;
            V0   <= (nxt0.cnt != '0);
            V1   <= (nxt1.cnt != '0);
            // A new fault in the clearing cycle keeps its flag set.
            err[0] <= (nxt0.ovf | nxt1.ovf) | (err[0] & ~clr_err);
            err[1] <= (nxt0.unf | nxt1.unf) | (err[1] & ~clr_err);
        end
    end

endmodule

// File: tb/tb_trenes_sensores.sv
// Bench for trenes_sensores: pulse-level reference model feeds a per-edge
// scoreboard; directed scenarios plus a randomized pulse phase.
module tb_trenes_sensores;

    localparam int DEB  = 4;
    localparam int CW   = 3;
    localparam int MAXC = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          E0 = 1'b0, X0 = 1'b0, E1 = 1'b0, X1 = 1'b0;
    logic          clr_err = 1'b0;
    logic          V0, V1;
    logic [CW-1:0] cnt0, cnt1;
    logic [1:0]    err;

    trenes_sensores #(.DEB_CYCLES(DEB), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .E0(E0), .X0(X0), .E1(E1), .X1(X1),
        .clr_err(clr_err), .V0(V0), .V1(V1), .cnt0(cnt0), .cnt1(cnt1), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    err;
        logic          v1;
        logic          v0;
        logic [CW-1:0] c1;
        logic [CW-1:0] c0;
    } snap_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    edge_n   = 0;
    snap_t exp_q[$];

    // Reference model: a pulse of at least DEB samples is one event, applied
    // DEB+3 edges after the first edge that sees it.
    int         occ[2] = '{0, 0};
    bit         ovf_f = 1'b0, unf_f = 1'b0;
    logic [3:0] ev_sched[int];
    bit         clr_sched[int];

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic schedule(input logic [3:0] mask, input int t);
        if (!ev_sched.exists(t)) ev_sched[t] = 4'b0;
        ev_sched[t] = ev_sched[t] | mask;
    endtask

    task automatic model_step(input int t);
        logic [3:0] ev;
        bit         clr, ov, un, e, x;
        snap_t      s;
        ev  = ev_sched.exists(t) ? ev_sched[t] : 4'b0;
        clr = clr_sched.exists(t);
        ov  = 1'b0;
        un  = 1'b0;
        for (int tr = 0; tr < 2; tr++) begin
            e = ev[2*tr];
            x = ev[2*tr+1];
            if (e && !x) begin
                if (occ[tr] < MAXC) occ[tr]++;
                else                ov = 1'b1;
            end else if (x && !e) begin
                if (occ[tr] > 0) occ[tr]--;
                else             un = 1'b1;
            end
        end
        ovf_f = (ovf_f && !clr) || ov;
        unf_f = (unf_f && !clr) || un;
        s.err = {unf_f, ovf_f};
        s.v1  = (occ[1] != 0);
        s.v0  = (occ[0] != 0);
        s.c1  = CW'(occ[1]);
        s.c0  = CW'(occ[0]);
        exp_q.push_back(s);
    endtask

    always @(posedge clk) begin
        edge_n++;
        if (reset === 1'b1) model_step(edge_n);
    end

    // Monitor: one observed state per edge, compared with the queued expectation.
    always @(negedge clk) begin
        snap_t got, want;
        if (reset === 1'b1) begin
            got = {err, V1, V0, cnt1, cnt0};
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard edge %0d: got 0x%0h, expected an entry but queue empty",
                         edge_n, got);
            end else begin
                want = exp_q.pop_front();
                check($sformatf("state{err,V1,V0,cnt1,cnt0} edge %0d", edge_n),
                      int'(got), int'(want));
            end
        end
    end

    task automatic set_raw(input logic [3:0] m);
        {X1, E1, X0, E0} = m;
    endtask

    // Called just after a negedge; returns just after a negedge.
    task automatic pulse(input logic [3:0] mask, input int len, input int gap);
        int t0;
        t0 = edge_n + 1;
        if (len >= DEB) schedule(mask, t0 + DEB + 3);
        set_raw(mask);
        repeat (len) @(negedge clk);
        set_raw(4'b0);
        repeat (gap) @(negedge clk);
    endtask

    task automatic clear_err_once();
        clr_sched[edge_n + 1] = 1'b1;
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic wait_v0(input logic lvl, input int t0, input string name);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (V0 === lvl) begin
                check(name, edge_n - t0, DEB + 3);
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: got no V0 change within 40 edges, expected one after %0d", name, DEB + 3);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " V0"}, int'(V0), 0);
        check({tag, " V1"}, int'(V1), 0);
        check({tag, " cnt0"}, int'(cnt0), 0);
        check({tag, " cnt1"}, int'(cnt1), 0);
        check({tag, " err"}, int'(err), 0);
    endtask

    // Asserts reset between edges while stimulus may be mid-debounce.
    task automatic reset_mid_cycle();
        @(posedge clk);
        #2;
        reset = 1'b0;
        exp_q.delete();
        ev_sched.delete();
        clr_sched.delete();
        occ   = '{0, 0};
        ovf_f = 1'b0;
        unf_f = 1'b0;
        #1;
        check_zero("async reset");
        set_raw(4'b0);
        clr_err = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         t0;
        logic [3:0] m;
        int         len, gap;

        reset = 1'b1;
        #1 reset = 1'b0;
        #1 check_zero("reset state");
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;

        // Single train on track 0 with exact latency checks.
        t0 = edge_n + 1;
        fork
            pulse(4'b0001, 6, 20);
            wait_v0(1'b1, t0, "V0 rise latency");
        join
        t0 = edge_n + 1;
        fork
            pulse(4'b0010, 6, 20);
            wait_v0(1'b0, t0, "V0 fall latency");
        join
        check("single train cnt0", int'(cnt0), 0);
        check("single train err", int'(err), 0);

        // Bounce and short glitch on E1 are rejected; a DEB-long pulse counts.
        repeat (4) pulse(4'b0100, 1, 1);
        pulse(4'b0100, 3, DEB + 4);
        check("bounce cnt1", int'(cnt1), 0);
        check("bounce V1", int'(V1), 0);
        pulse(4'b0100, 4, DEB + 8);
        check("min pulse cnt1", int'(cnt1), 1);

        // Saturation at 2^CNT_W-1 and error clear.
        repeat (8) pulse(4'b0001, 5, DEB + 4);
        check("sat cnt0", int'(cnt0), MAXC);
        check("sat err", int'(err), 1);
        check("sat V0", int'(V0), 1);
        clear_err_once();
        check("clr err", int'(err), 0);
        check("clr cnt0", int'(cnt0), MAXC);

        // Underflow, then simultaneous entry/exit.
        pulse(4'b1000, 5, DEB + 4);
        pulse(4'b1000, 5, DEB + 4);
        check("underflow err", int'(err), 2);
        check("underflow cnt1", int'(cnt1), 0);
        repeat (5) pulse(4'b0010, 5, DEB + 4);
        check("drain cnt0", int'(cnt0), 2);
        pulse(4'b0011, 5, DEB + 4);
        check("simul cnt0", int'(cnt0), 2);
        check("simul err", int'(err), 2);

        // Clear in the very cycle a new underflow lands: the error wins.
        fork
            pulse(4'b1000, 5, DEB + 4);
            begin
                repeat (DEB + 3) @(negedge clk);
                clear_err_once();
            end
        join
        check("clear vs new error", int'(err), 2);
        clear_err_once();

        // Parallel tracks, then reset during an E0 debounce.
        repeat (2) pulse(4'b0010, 5, DEB + 4);
        pulse(4'b0101, 5, DEB + 4);
        check("parallel cnt0", int'(cnt0), 1);
        check("parallel cnt1", int'(cnt1), 1);
        check("parallel V", int'({V1, V0}), 3);
        set_raw(4'b0001);
        repeat (3) @(negedge clk);
        reset_mid_cycle();
        repeat (20) @(negedge clk);
        check_zero("after reset");

        // Randomized pulses and occasional clears.
        repeat (60) begin
            m   = 4'($urandom_range(1, 15));
            len = $urandom_range(1, 7);
            gap = $urandom_range(DEB, DEB + 5);
            pulse(m, len, gap);
            if ($urandom_range(0, 7) == 0) clear_err_once();
        end
        repeat (DEB + 10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trenes_sensores.md
# trenes_sensores

Upstream conditioner for the two-track crossing controller. It cleans the raw entry and exit sensors of track 0 and track 1 and tracks how many trains occupy each protected section. It drives the V0/V1 occupancy requests that the crossing FSM consumes: each one asserts while its section holds at least one train. Raw sensors are asynchronous and bouncy, so every input is synchronized and debounced before it is used.

## Interface
- DEB_CYCLES, 4: consecutive stable samples needed to accept a new sensor level (legal range 2..255).
- CNT_W, 3: width of each occupancy counter; maximum count is 2^CNT_W-1.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; 0 forces every register to its reset value immediately.
- E0, X0  in  1  raw entry and exit sensors for track 0, active-high, asynchronous.
- E1, X1  in  1  raw entry and exit sensors for track 1, active-high, asynchronous.
- clr_err  in  1  synchronous clear of the err flags.
- V0, V1  out  1  section occupied (cntN != 0), registered.
- cnt0, cnt1  out  CNT_W  occupancy count per track, registered.
- err  out  2  sticky fault flags: bit0 = overflow on either track, bit1 = underflow on either track.

## Operation
- Four identical sensor channels (E0, X0, E1, X1), each with:
  - a 2-flop synchronizer (s1, s2);
  - a debounce stage: a stable register and a run counter of width clog2(DEB_CYCLES).
- Debounce rule, evaluated each cycle:
  - if s2 == stable, the run counter resets to 0;
  - otherwise the run counter increments;
  - when s2 != stable and the run counter == DEB_CYCLES-1, stable <= s2 and the run counter resets to 0.
  - Any pulse shorter than DEB_CYCLES samples is discarded.
- Event pulse: evN <= stable & ~stable_d, registered, one cycle wide. Only rising edges count; falling edges generate nothing.
- Occupancy update per track, on the cycle its event registers are high:
  - entry only, cnt < max: cnt+1.
  - entry only, cnt == max: cnt holds (saturates), err[0] <= 1.
  - exit only, cnt > 0: cnt-1.
  - exit only, cnt == 0: cnt stays 0, err[1] <= 1.
  - entry and exit in the same cycle: cnt unchanged, no error.
- VN <= (next cntN != 0). V changes on the same edge as cnt and is never combinational.
- Tracks 0 and 1 are fully independent; simultaneous events on both tracks are both applied.
- err bits are sticky until clr_err = 1 is sampled. If a clear and a new error occur in the same cycle, the new error wins and the bit stays 1.
- Reset mid-operation discards all counts, in-flight debounce runs and events. No state survives reset.

## Timing
- Reset values: V0=0, V1=0, cnt0=0, cnt1=0, err=2'b00. All internal s1, s2, stable, stable_d, run counters and event registers are 0.
- Latency, raw rise to V/cnt update, with the raw input steady from before edge k:
  - s1 at edge k, s2 at k+1;
  - stable at k+1+DEB_CYCLES;
  - event at k+2+DEB_CYCLES;
  - cnt/V at k+3+DEB_CYCLES.
  - With the default DEB_CYCLES=4 this is 8 edges.
- Exit path latency is identical, so V falls k+3+DEB_CYCLES after the exit sensor rises.
- Minimum spacing between accepted events on one sensor is 2*DEB_CYCLES cycles (high run plus low run).
- After reset deassertion, the first possible V assertion is 3+DEB_CYCLES edges after an entry sensor is already high. An input held high through reset therefore counts as one entry.

## Test plan
- Single train, DEB_CYCLES=4: hold reset=0 for 3 cycles, release. Pulse E0 high for 6 cycles, then after 20 cycles pulse X0 high for 6 cycles. Required: V0 rises exactly 8 edges after E0 rises and falls exactly 8 edges after X0 rises; cnt0 goes 0->1->0; err=00.
- Bounce rejection: E1 toggles 1,0,1,0 every cycle for 8 cycles, then a 3-cycle high glitch. Required: cnt1=0, V1=0 throughout. A following 4-cycle high pulse gives cnt1=1.
- Saturation, CNT_W=3: issue 8 clean E0 pulses. Required: cnt0 stops at 7, err[0]=1 after the 8th, V0=1. Then clr_err=1 for one cycle: err=00, cnt0 still 7.
- Underflow and simultaneity: X1 pulse with cnt1=0 gives err[1]=1, cnt1=0. With cnt0=2, E0 and X0 pulsed on the same cycle give cnt0=2 and no new error.
- Parallel tracks plus reset mid-operation: drive E0 and E1 together, giving cnt0=cnt1=1 and V0=V1=1 on the same edge. Assert reset=0 between edges while a new E0 debounce is in progress. Required: V0, V1, cnt0, cnt1 and err are all 0 immediately, without waiting for a clock edge, and no event appears after release unless E0 is still high.
